// File: rtl/dds_sweep_ctrl_pkg.sv
// dds_pkg: shared DDS channel constants, sweep state encoding, wave-select codes and dwell helper.
package dds_pkg;
    localparam int FCW_W   = 32;
    localparam int DWELL_W = 24;
    localparam int FCLK_HZ = 24_000_000;
    localparam logic [FCW_W-1:0] RST_FCW = 32'd178957;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN_UP, ST_RUN_DN, ST_DONE} sweep_state_t;
    typedef enum logic [2:0] {WAVE_IDLE, WAVE_SIN, WAVE_SQU, WAVE_TRI, WAVE_SAW} wave_sel_t;
    function automatic logic [DWELL_W-1:0] dwell_eff(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction
endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: sweep configuration/control inputs and FCW/status outputs of one DDS channel.
interface dds_sweep_ctrl_if;
    import dds_pkg::*;
    logic               cfg_load;
    logic [FCW_W-1:0]   start_fcw;
    logic [FCW_W-1:0]   stop_fcw;
    logic [FCW_W-1:0]   step_fcw;
    logic [DWELL_W-1:0] dwell_cyc;
    logic               cont_mode;
    logic               bidir_mode;
    logic               sweep_en;
    logic [FCW_W-1:0]   fcw_out;
    logic               sweep_busy;
    logic               sweep_done;
    logic               phase_rst_n;
    modport master (
        output cfg_load, start_fcw, stop_fcw, step_fcw, dwell_cyc, cont_mode, bidir_mode, sweep_en,
        input  fcw_out, sweep_busy, sweep_done, phase_rst_n
    );
    modport slave (
        input  cfg_load, start_fcw, stop_fcw, step_fcw, dwell_cyc, cont_mode, bidir_mode, sweep_en,
        output fcw_out, sweep_busy, sweep_done, phase_rst_n
    );
endinterface

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// dds_dwell_timer: loadable down-counter; o_tick is high while the count sits at zero.
module dds_dwell_timer
    import dds_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_val,
    output logic               o_tick
);
    logic [DWELL_W-1:0] r_cnt;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (i_clr || r_cnt == '0) r_cnt <= '0;
        else r_cnt <= r_cnt - DWELL_W'(1);
    end
    assign o_tick = (r_cnt == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: DDS FCW sweep sequencer with dwell, clamping and a phase-reset pulse per (re)start.
// DDS_SWEEP_BIDIR_EN adds the RUN_DN leg for triangle sweeps; without it only sawtooth sweeps exist.
module dds_sweep_ctrl
    import dds_pkg::*;
(
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    dds_sweep_ctrl_if.slave bus
);
    sweep_state_t       r_state;
    logic [FCW_W-1:0]   r_fcw, r_start, r_stop, r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_cont, r_busy, r_done, r_prst_n, r_en_d, r_rise;
    logic               w_run, w_tick, w_load;
    logic [DWELL_W-1:0] w_dwell_m1;
    logic [FCW_W:0]     w_up;
    logic [FCW_W-1:0]   w_up_clamp;
`ifdef DDS_SWEEP_BIDIR_EN
    logic               r_bidir, w_dn_hit;
    logic [FCW_W:0]     w_dn;
    logic [FCW_W-1:0]   w_dn_clamp;
    assign w_dn       = {1'b0, r_fcw} - {1'b0, r_step};
    assign w_dn_hit   = w_dn[FCW_W] || (w_dn[FCW_W-1:0] <= r_start);
    assign w_dn_clamp = w_dn_hit ? r_start : w_dn[FCW_W-1:0];
`endif
    // 33-bit sum so a carry out of the FCW still clamps to stop instead of wrapping
    assign w_up       = {1'b0, r_fcw} + {1'b0, r_step};
    assign w_up_clamp = (w_up >= {1'b0, r_stop}) ? r_stop : w_up[FCW_W-1:0];
    assign w_run      = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DN);
    assign w_load     = ((r_state == ST_IDLE) && r_rise) || (w_run && bus.sweep_en && w_tick);
    assign w_dwell_m1 = dwell_eff(r_dwell) - DWELL_W'(1);
    dds_dwell_timer u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_clr     (!w_run),
        .i_load    (w_load),
        .i_val     (w_dwell_m1),
        .o_tick    (w_tick)
    );
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= ST_IDLE;
            r_fcw    <= RST_FCW;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_prst_n <= 1'b1;
            r_en_d   <= 1'b0;
            r_rise   <= 1'b0;
            r_start  <= RST_FCW;
            r_stop   <= RST_FCW;
            r_step   <= '0;
            r_dwell  <= DWELL_W'(1);
            r_cont   <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
            r_bidir  <= 1'b0;
`endif
        end else begin
            r_en_d   <= bus.sweep_en;
            r_rise   <= bus.sweep_en && !r_en_d;
            r_done   <= 1'b0;
            r_prst_n <= 1'b1;
            if (r_state == ST_IDLE) begin
                if (bus.cfg_load) begin
                    r_start <= bus.start_fcw;
                    r_stop  <= bus.stop_fcw;
                    r_step  <= bus.step_fcw;
                    r_dwell <= bus.dwell_cyc;
                    r_cont  <= bus.cont_mode;
`ifdef DDS_SWEEP_BIDIR_EN
                    r_bidir <= bus.bidir_mode;
`endif
                end
                if (r_rise) begin
                    r_state  <= ST_RUN_UP;
                    r_fcw    <= r_start;
                    r_busy   <= 1'b1;
                    r_prst_n <= 1'b0;
                end
            end else if (!bus.sweep_en || r_state == ST_DONE) begin
                r_state <= ST_IDLE;
                r_fcw   <= RST_FCW;
                r_busy  <= 1'b0;
            end else if (w_tick) begin
`ifdef DDS_SWEEP_BIDIR_EN
                if (r_state == ST_RUN_DN) begin
                    if (r_fcw <= r_start) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_fcw <= w_dn_clamp;
                        if (w_dn_hit && r_cont) begin
                            r_state  <= ST_RUN_UP;
                            r_prst_n <= 1'b0;
                        end
                    end
                end else if (r_fcw < r_stop) begin
                    r_fcw <= w_up_clamp;
                end else if (r_bidir) begin
                    r_fcw <= w_dn_clamp;
                    if (w_dn_hit && r_cont) r_prst_n <= 1'b0;
                    else r_state <= ST_RUN_DN;
                end else
`else
                if (r_fcw < r_stop) begin
                    r_fcw <= w_up_clamp;
                end else
`endif
                if (r_cont) begin
                    r_fcw    <= r_start;
                    r_prst_n <= 1'b0;
                end else begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end
    assign bus.fcw_out     = r_fcw;
    assign bus.sweep_busy  = r_busy;
    assign bus.sweep_done  = r_done;
    assign bus.phase_rst_n = r_prst_n;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed sweep sequences for dds_sweep_ctrl with hand-computed FCW timelines.
module tb_dds_sweep_ctrl;
    localparam logic [31:0] RST = 32'd178957;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    dds_sweep_ctrl_if bus();
    dds_sweep_ctrl dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0b want %0b", tag, obs, exp);
        end
    endtask
    task automatic hold(input string tag, input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, bus.fcw_out, val);
            tick();
        end
    endtask
    task automatic cfg(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                       input logic [23:0] d, input logic c, input logic b);
        bus.start_fcw  = s;
        bus.stop_fcw   = p;
        bus.step_fcw   = st;
        bus.dwell_cyc  = d;
        bus.cont_mode  = c;
        bus.bidir_mode = b;
        bus.cfg_load   = 1'b1;
        tick();
        bus.cfg_load   = 1'b0;
    endtask
    task automatic go();
        bus.sweep_en = 1'b1;
        tick();
        tick();
    endtask
    task automatic stop_en();
        bus.sweep_en = 1'b0;
        tick();
    endtask
    initial begin
        bus.cfg_load = 1'b0;
        bus.start_fcw = '0;
        bus.stop_fcw = '0;
        bus.step_fcw = '0;
        bus.dwell_cyc = '0;
        bus.cont_mode = 1'b0;
        bus.bidir_mode = 1'b0;
        bus.sweep_en = 1'b0;
        tick();
        chk("rst_fcw", bus.fcw_out, RST);
        chk1("rst_busy", bus.sweep_busy, 1'b0);
        chk1("rst_done", bus.sweep_done, 1'b0);
        chk1("rst_prst", bus.phase_rst_n, 1'b1);
        rst_n = 1'b1;
        tick();
        // single shot 1000..1300 step 100 dwell 4
        cfg(1000, 1300, 100, 4, 1'b0, 1'b0);
        go();
        chk1("t1_prst_lo", bus.phase_rst_n, 1'b0);
        chk1("t1_busy", bus.sweep_busy, 1'b1);
        hold("t1_1000a", 1000, 1);
        chk1("t1_prst_hi", bus.phase_rst_n, 1'b1);
        hold("t1_1000b", 1000, 3);
        hold("t1_1100", 1100, 4);
        hold("t1_1200", 1200, 4);
        hold("t1_1300", 1300, 4);
        chk1("t1_done", bus.sweep_done, 1'b1);
        chk1("t1_done_busy", bus.sweep_busy, 1'b0);
        chk("t1_done_fcw", bus.fcw_out, 1300);
        tick();
        chk1("t1_done_pulse", bus.sweep_done, 1'b0);
        chk("t1_idle_fcw", bus.fcw_out, RST);
        chk1("t1_idle_busy", bus.sweep_busy, 1'b0);
        stop_en();
        // continuous with clamp at 1250, then abort at 1100
        cfg(1000, 1250, 100, 2, 1'b1, 1'b0);
        go();
        hold("t2_1000", 1000, 2);
        hold("t2_1100", 1100, 2);
        hold("t2_1200", 1200, 2);
        hold("t2_1250", 1250, 2);
        chk1("t2_restart_prst", bus.phase_rst_n, 1'b0);
        hold("t2_1000r", 1000, 2);
        chk1("t2_prst_hi", bus.phase_rst_n, 1'b1);
        chk("t2_1100r", bus.fcw_out, 1100);
        stop_en();
        chk("t4_abort_fcw", bus.fcw_out, RST);
        chk1("t4_abort_busy", bus.sweep_busy, 1'b0);
        chk1("t4_abort_done", bus.sweep_done, 1'b0);
        tick();
        chk1("t4_abort_done2", bus.sweep_done, 1'b0);
`ifdef DDS_SWEEP_BIDIR_EN
        cfg(0, 300, 100, 1, 1'b1, 1'b1);
        go();
        hold("t3_0", 0, 1);
        hold("t3_100", 100, 1);
        hold("t3_200", 200, 1);
        hold("t3_300", 300, 1);
        hold("t3_200d", 200, 1);
        hold("t3_100d", 100, 1);
        chk1("t3_prst", bus.phase_rst_n, 1'b0);
        hold("t3_0r", 0, 1);
        hold("t3_100r", 100, 1);
        stop_en();
`endif
        // carry clamp near full scale, dwell 0 acts as 1
        cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 200, 0, 1'b0, 1'b0);
        go();
        hold("t5_start", 32'hFFFF_FF00, 1);
        hold("t5_mid", 32'hFFFF_FFC8, 1);
        hold("t5_clamp", 32'hFFFF_FFFF, 1);
        chk1("t5_done", bus.sweep_done, 1'b1);
        chk("t5_done_fcw", bus.fcw_out, 32'hFFFF_FFFF);
        tick();
        stop_en();
        // zero step never ends
        cfg(1000, 2000, 0, 1, 1'b0, 1'b0);
        go();
        hold("t5_step0", 1000, 20);
        chk1("t5_step0_busy", bus.sweep_busy, 1'b1);
        stop_en();
        chk1("t5_step0_abort", bus.sweep_busy, 1'b0);
        // start above stop: one dwell at start, then done
        cfg(500, 400, 7, 3, 1'b0, 1'b0);
        go();
        hold("t5_inv", 500, 3);
        chk1("t5_inv_done", bus.sweep_done, 1'b1);
        tick();
        stop_en();
        // cfg_load while busy is ignored
        cfg(1000, 1300, 100, 2, 1'b1, 1'b0);
        go();
        hold("t6_1000a", 1000, 1);
        bus.start_fcw = 5000;
        bus.cfg_load = 1'b1;
        hold("t6_1000b", 1000, 1);
        bus.cfg_load = 1'b0;
        hold("t6_1100", 1100, 2);
        hold("t6_1200", 1200, 2);
        hold("t6_1300", 1300, 2);
        chk1("t6_restart_prst", bus.phase_rst_n, 1'b0);
        hold("t6_restart", 1000, 1);
        // asynchronous reset mid-sweep
        rst_n = 1'b0;
        #1;
        chk("t6_arst_fcw", bus.fcw_out, RST);
        chk1("t6_arst_busy", bus.sweep_busy, 1'b0);
        chk1("t6_arst_prst", bus.phase_rst_n, 1'b1);
        chk1("t6_arst_done", bus.sweep_done, 1'b0);
        bus.sweep_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_post_fcw", bus.fcw_out, RST);
        // reset config: start=stop=RST_FCW, single shot
        go();
        chk("t6_rcfg_fcw", bus.fcw_out, RST);
        chk1("t6_rcfg_prst", bus.phase_rst_n, 1'b0);
        chk1("t6_rcfg_busy", bus.sweep_busy, 1'b1);
        tick();
        chk1("t6_rcfg_done", bus.sweep_done, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk1("t6_no_restart", bus.sweep_busy, 1'b0);
            tick();
        end
        chk("t6_hold_idle", bus.fcw_out, RST);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
